share_unmask_serial: RTL and testbench

- Recombination end of the masked datapath: accepts one (security_order+1)-share Boolean-masked word and returns the unmasked value.
- Sits at the output boundary of the masked gadget pipeline (HPC3 AND/NOR networks), e.g. ciphertext release.
- XORs shares into an accumulator serially, one share per cycle, so no combinational cone ever sees all shares at once.
- Valid/ready handshake on both sides.

---
 rtl/share_unmask_serial.sv | 145 ++++++++++++++
 tb/tb_share_unmask_serial.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/share_unmask_serial.sv
// -----------------------------------------------------------------------------
// share_unmask_serial
//
// Purpose:
//   This is the recombination end of a Boolean-masked datapath. It accepts one
//   word split into (security_order+1) shares and returns the unmasked value.
//   The shares are folded into an accumulator one per clock. No combinational
//   cone ever combines all shares of a word at the same time.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_shares holds a word
//   in_ready   out  block can capture a word (high only in IDLE)
//   in_shares  in   (security_order+1)*width bits; share i at [i*width +: width]
//   out_valid  out  out_data holds the unmasked word (high only in DONE)
//   out_ready  in   downstream accepts out_data
//   out_data   out  unmasked word; forced to zero whenever out_valid is low
//   busy       out  high in ACC or DONE
//
// Configuration:
//   SHARE_UNMASK_ZEROIZE_EN - when defined, the share registers and the
//   accumulator are cleared on the DONE->IDLE edge, so no share material
//   persists after a word is released. Port behaviour is identical either way.
// -----------------------------------------------------------------------------
module share_unmask_serial #(
    parameter int security_order = 1,
    parameter int width          = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [(security_order+1)*width-1:0] in_shares,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [width-1:0]                    out_data,
    output logic                                busy
);

    localparam int NSH   = security_order + 1;
    localparam int CNT_W = (NSH > 1) ? $clog2(NSH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [width-1:0]   acc_q, acc_d;
    logic [width-1:0]   share_q [NSH];
    logic [width-1:0]   share_d [NSH];
    logic [width-1:0]   share_sel;

    // One-share mux. The select is the registered counter, so only the chosen
    // share reaches the XOR in any cycle.
    always_comb begin
        share_sel = '0;
        for (int i = 0; i < NSH; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                share_sel = share_q[i];
            end
        end
    end

    // Next-state / datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        for (int i = 0; i < NSH; i++) begin
            share_d[i] = share_q[i];
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < NSH; i++) begin
                        share_d[i] = in_shares[i*width +: width];
                    end
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACC;
                end
            end

            ACC: begin
                acc_d = acc_q ^ share_sel;
                if (cnt_q == CNT_W'(security_order)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
`ifdef SHARE_UNMASK_ZEROIZE_EN
                    // Scrub all share material on release.
                    acc_d = '0;
                    for (int i = 0; i < NSH; i++) begin
                        share_d[i] = '0;
                    end
`endif
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            for (int i = 0; i < NSH; i++) begin
                share_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            for (int i = 0; i < NSH; i++) begin
                share_q[i] <= share_d[i];
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ACC) || (state_q == DONE);

    // The accumulator holds partial XOR sums while in ACC. Gating it with the
    // DONE decode keeps those sums off the port.
    assign out_data  = acc_q & {width{out_valid}};

endmodule

// File: tb/tb_share_unmask_serial.sv
// -----------------------------------------------------------------------------
// tb_share_unmask_serial
//
// Self-checking bench for share_unmask_serial. It instantiates two copies of the
// design, one with security_order=1 and one with security_order=3 (width 8 in
// both). Expected values come from a plain XOR-of-shares reference and from the
// cycle timing of the handshake protocol. Internal register contents are
// checked hierarchically after release. These checks depend on whether
// SHARE_UNMASK_ZEROIZE_EN is defined.
// -----------------------------------------------------------------------------
module tb_share_unmask_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // security_order = 1 instance
    logic        rst_n1, in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [15:0] in_shares1;
    logic [7:0]  out_data1;

    // security_order = 3 instance
    logic        rst_n3, in_valid3, in_ready3, out_valid3, out_ready3, busy3;
    logic [31:0] in_shares3;
    logic [7:0]  out_data3;

    share_unmask_serial #(.security_order(1), .width(8)) u1 (
        .clk       (clk),
        .rst_n     (rst_n1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_shares (in_shares1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .busy      (busy1)
    );

    share_unmask_serial #(.security_order(3), .width(8)) u3 (
        .clk       (clk),
        .rst_n     (rst_n3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_shares (in_shares3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3),
        .busy      (busy3)
    );

    // Reference model: the unmasked word is the XOR of all shares.
    function automatic logic [7:0] unmask2(input logic [15:0] s);
        return s[7:0] ^ s[15:8];
    endfunction

    function automatic logic [7:0] unmask4(input logic [31:0] s);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 4; i++) r ^= s[i*8 +: 8];
        return r;
    endfunction

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n1 = 1'b0; rst_n3 = 1'b0;
        in_valid1 = 1'b0; in_valid3 = 1'b0;
        out_ready1 = 1'b1; out_ready3 = 1'b1;
        in_shares1 = '0; in_shares3 = '0;
        tick();
        tick();
        n_tests++;
        if ({in_ready1, out_valid1, busy1} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ctrl_d1: got rdy/vld/busy=%b required 100", {in_ready1, out_valid1, busy1});
        end
        n_tests++;
        if (out_data1 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data_d1: got %h required 00", out_data1);
        end
        n_tests++;
        if ({in_ready3, out_valid3, busy3} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ctrl_d3: got rdy/vld/busy=%b required 100", {in_ready3, out_valid3, busy3});
        end
        n_tests++;
        if ({u1.acc_q, u1.share_q[0], u1.share_q[1]} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_regs_d1: got acc/s0/s1=%h required 000000", {u1.acc_q, u1.share_q[0], u1.share_q[1]});
        end
        rst_n1 = 1'b1; rst_n3 = 1'b1;
        tick();
    endtask

    task automatic test_basic_d1();
        logic [7:0] exp_acc, exp_s0, exp_s1;
        in_shares1 = {8'h5A, 8'h3C};
        in_valid1  = 1'b1;
        out_ready1 = 1'b1;
        tick();                              // capture edge
        in_valid1  = 1'b0;
        in_shares1 = 16'hDEAD;               // must be ignored
        n_tests++;
        if ({in_ready1, out_valid1, busy1, out_data1} !== {3'b001, 8'h00}) begin
            n_fail++;
            $display("FAIL basic_acc0: got rdy/vld/busy=%b data=%h required 001 data=00", {in_ready1, out_valid1, busy1}, out_data1);
        end
        tick();
        n_tests++;
        if ({out_valid1, out_data1} !== {1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL basic_acc1: got vld=%b data=%h required 0/00", out_valid1, out_data1);
        end
        tick();
        n_tests++;
        if ({out_valid1, out_data1} !== {1'b1, 8'h66}) begin
            n_fail++;
            $display("FAIL basic_done: got vld=%b data=%h required 1/66", out_valid1, out_data1);
        end
        tick();
        n_tests++;
        if ({in_ready1, out_valid1, busy1, out_data1} !== {3'b100, 8'h00}) begin
            n_fail++;
            $display("FAIL basic_idle: got rdy/vld/busy=%b data=%h required 100 data=00", {in_ready1, out_valid1, busy1}, out_data1);
        end
`ifdef SHARE_UNMASK_ZEROIZE_EN
        exp_acc = 8'h00; exp_s0 = 8'h00; exp_s1 = 8'h00;
`else
        exp_acc = 8'h66; exp_s0 = 8'h3C; exp_s1 = 8'h5A;
`endif
        n_tests++;
        if ({u1.acc_q, u1.share_q[0], u1.share_q[1]} !== {exp_acc, exp_s0, exp_s1}) begin
            n_fail++;
            $display("FAIL zeroize_regs: got acc/s0/s1=%h required %h", {u1.acc_q, u1.share_q[0], u1.share_q[1]}, {exp_acc, exp_s0, exp_s1});
        end
    endtask

    task automatic test_d3();
        in_shares3 = {8'h80, 8'h04, 8'h02, 8'h01};
        in_valid3  = 1'b1;
        out_ready3 = 1'b1;
        tick();                              // capture edge
        in_valid3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({out_valid3, out_data3} !== {1'b0, 8'h00}) begin
                n_fail++;
                $display("FAIL d3_pre%0d: got vld=%b data=%h required 0/00", i, out_valid3, out_data3);
            end
            tick();
        end
        n_tests++;
        if ({out_valid3, out_data3} !== {1'b1, 8'h87}) begin
            n_fail++;
            $display("FAIL d3_done: got vld=%b data=%h required 1/87", out_valid3, out_data3);
        end
        tick();
        n_tests++;
        if ({in_ready3, out_valid3} !== 2'b10) begin
            n_fail++;
            $display("FAIL d3_idle: got rdy/vld=%b required 10", {in_ready3, out_valid3});
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        in_shares1 = {8'h0F, 8'hFF};
        in_valid1  = 1'b1;
        out_ready1 = 1'b0;
        tick();
        in_valid1 = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if ({in_ready1, out_valid1, out_data1} !== {2'b01, 8'hF0}) begin
                n_fail++;
                bad++;
                if (bad < 4)
                    $display("FAIL bp_hold%0d: got rdy/vld=%b data=%h required 01 data=f0", i, {in_ready1, out_valid1}, out_data1);
            end
            tick();
        end
        out_ready1 = 1'b1;
        tick();
        n_tests++;
        if ({in_ready1, out_valid1, busy1} !== 3'b100) begin
            n_fail++;
            $display("FAIL bp_release: got rdy/vld/busy=%b required 100", {in_ready1, out_valid1, busy1});
        end
    endtask

    // in_valid held high and shares randomised every cycle. With d=1 the word
    // period is 4: capture from the sample with t%4==0, result visible at t%4==3.
    task automatic test_back_to_back();
        logic [7:0] exp_word = 8'h00;
        out_ready1 = 1'b1;
        in_valid1  = 1'b1;
        for (int t = 0; t < 24; t++) begin
            n_tests++;
            if ({in_ready1, out_valid1} !== {1'(t % 4 == 0), 1'(t % 4 == 3)}) begin
                n_fail++;
                $display("FAIL b2b_timing t=%0d: got rdy/vld=%b required %b", t, {in_ready1, out_valid1}, {1'(t % 4 == 0), 1'(t % 4 == 3)});
            end
            if (t % 4 == 3) begin
                n_tests++;
                if (out_data1 !== exp_word) begin
                    n_fail++;
                    $display("FAIL b2b_data t=%0d: got %h required %h", t, out_data1, exp_word);
                end
            end
            in_shares1 = 16'($urandom);
            if (t % 4 == 0) exp_word = unmask2(in_shares1);
            tick();
        end
        in_valid1 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_acc();
        int seen = 0;
        in_shares1 = {8'h22, 8'h11};
        in_valid1  = 1'b1;
        out_ready1 = 1'b1;
        tick();                              // capture
        in_valid1 = 1'b0;
        tick();                              // first ACC edge
        rst_n1 = 1'b0;
        #1;
        n_tests++;
        if ({in_ready1, out_valid1, busy1, out_data1} !== {3'b100, 8'h00}) begin
            n_fail++;
            $display("FAIL rst_mid_immediate: got rdy/vld/busy=%b data=%h required 100 data=00", {in_ready1, out_valid1, busy1}, out_data1);
        end
        tick();
        rst_n1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid1 !== 1'b0) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_result: got %0d out_valid cycles required 0", seen);
        end
        in_shares1 = {8'h55, 8'hAA};
        in_valid1  = 1'b1;
        tick();
        in_valid1 = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({out_valid1, out_data1} !== {1'b1, 8'hFF}) begin
            n_fail++;
            $display("FAIL rst_mid_next_word: got vld=%b data=%h required 1/ff", out_valid1, out_data1);
        end
        tick();
    endtask

    // Random words on d=3 with churn on in_shares during ACC and random
    // back-pressure in DONE.
    task automatic test_random_d3();
        logic [31:0] word;
        logic [7:0]  exp_word;
        int          lat, hold, leak;
        for (int it = 0; it < 20; it++) begin
            word       = $urandom;
            exp_word   = unmask4(word);
            in_shares3 = word;
            in_valid3  = 1'b1;
            out_ready3 = 1'($urandom_range(0, 1));
            tick();
            in_valid3 = 1'b0;
            lat  = 0;
            leak = 0;
            while (out_valid3 !== 1'b1 && lat < 10) begin
                if (out_data3 !== 8'h00) leak++;
                in_shares3 = $urandom;
                tick();
                lat++;
            end
            n_tests++;
            if (lat != 4 || leak != 0) begin
                n_fail++;
                $display("FAIL rnd_latency it=%0d: got %0d edges (%0d nonzero data) required 4 (0)", it, lat, leak);
            end
            n_tests++;
            if ({out_valid3, out_data3} !== {1'b1, exp_word}) begin
                n_fail++;
                $display("FAIL rnd_data it=%0d: got vld=%b data=%h required 1/%h", it, out_valid3, out_data3, exp_word);
            end
            hold = $urandom_range(1, 3);
            out_ready3 = 1'b0;
            for (int h = 0; h < hold; h++) begin
                in_shares3 = $urandom;
                tick();
                n_tests++;
                if ({in_ready3, out_valid3, out_data3} !== {2'b01, exp_word}) begin
                    n_fail++;
                    $display("FAIL rnd_hold it=%0d: got rdy/vld=%b data=%h required 01 data=%h", it, {in_ready3, out_valid3}, out_data3, exp_word);
                end
            end
            out_ready3 = 1'b1;
            tick();
            n_tests++;
            if ({in_ready3, out_valid3, busy3} !== 3'b100) begin
                n_fail++;
                $display("FAIL rnd_release it=%0d: got rdy/vld/busy=%b required 100", it, {in_ready3, out_valid3, busy3});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_d1();
        test_d3();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_acc();
        test_random_d3();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
